// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: 1-to-CH valid/ready stream demultiplexer with a one-entry registered slot per channel.
// Optional macro DEMUX_LOCK_EN keeps every beat of a packet (up to in_last) on the channel chosen by its first beat.
module demux_stream_1xn #(
    parameter int  WIDTH = 8,
    parameter int  CH    = 4,
    localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CH*WIDTH-1:0] out_data,
    output logic [CH-1:0]       out_valid,
    input  logic [CH-1:0]       out_ready,
    output logic [7:0]          err_cnt
);

    logic [SEL_W-1:0] esel;
    logic             sel_ok;
    logic [CH-1:0]    sel_hit;
    logic [CH-1:0]    wr_en;
    logic             accept;
    logic [CH-1:0]    slot_valid;
    logic [WIDTH-1:0] slot_data [CH];

`ifdef DEMUX_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] locked_sel;

    // The channel is captured from the first beat of a multi-beat packet, even if it is out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            locked_sel <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && !in_last) begin
                locked_sel <= in_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !in_last) state_nxt = LOCKED;
            LOCKED:  if (accept && in_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign esel = (state == LOCKED) ? locked_sel : in_sel;
`else
    logic unused_last;

    assign unused_last = in_last;
    assign esel        = in_sel;
`endif

    // Decoding against the real channel list also flags selects that fall beyond CH.
    always_comb begin
        sel_hit = '0;
        for (int i = 0; i < CH; i++) begin
            if (esel == SEL_W'(i)) begin
                sel_hit[i] = 1'b1;
            end
        end
    end

    assign sel_ok = |sel_hit;

    // Out-of-range beats are always taken so they can be dropped and counted.
    always_comb begin
        in_ready = 1'b1;
        if (sel_ok) begin
            in_ready = |(sel_hit & (~slot_valid | out_ready));
        end
        if (reset) begin
            in_ready = 1'b0;
        end
    end

    assign accept = in_valid & in_ready;
    assign wr_en  = accept ? sel_hit : '0;

    // A write wins over a drain on the same channel, so a slot can refill on the edge it empties.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            for (int i = 0; i < CH; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (wr_en[i]) begin
                    slot_data[i]  <= in_data;
                    slot_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (accept && !sel_ok && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < CH; i++) begin
            out_data[i*WIDTH +: WIDTH] = slot_data[i];
        end
    end

    assign out_valid = slot_valid;

endmodule

// File: doc/demux_stream_1xn.md
# demux_stream_1xn

Parametrised 1-to-N streaming demultiplexer with a valid/ready handshake and a one-entry registered output slot per channel. It is the next generation of the 1x4 combinational demux: generic data width and channel count, backpressure per channel, out-of-range select detection, and optional packet-locked routing. It sits between a single producer and N independent consumers in the datapath.

## Interface
- WIDTH, 8, data bits per beat
- CH, 4, number of output channels (2..16)
- SEL_W, derived localparam = max(1, clog2(CH)), select width; not overridable
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  input beat payload
- in_sel  input  SEL_W  destination channel index
- in_last  input  1  last beat of packet; used only when DEMUX_LOCK_EN is defined, ignored otherwise
- in_valid  input  1  input beat present
- in_ready  output  1  input beat accepted this cycle when in_valid & in_ready
- out_data  output  CH*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH]
- out_valid  output  CH  per-channel slot full
- out_ready  input  CH  per-channel consumer accept
- err_cnt  output  8  saturating count of dropped out-of-range beats

## Operation
- One clock domain. Reset is synchronous and active-high.
- Each channel i has a slot holding data_i and valid_i. out_data slice i = data_i. out_valid[i] = valid_i.
- Effective select: esel = in_sel in IDLE; esel = locked_sel in LOCKED (lock mode only).
- in_ready:
  - esel < CH: in_ready = !valid[esel] | out_ready[esel]. This is a combinational pass-through from out_ready.
  - esel >= CH: in_ready = 1.
- Accept (in_valid & in_ready) with esel < CH: data[esel] <= in_data and valid[esel] <= 1 on the next edge.
- Accept with esel >= CH: the beat is dropped. err_cnt increments and saturates at 255. No slot changes.
- Channel drain: if valid_i & out_ready[i] and channel i is not written this cycle, valid_i <= 0. A simultaneous drain and write on the same channel keeps valid_i = 1 and loads the new data.
- Non-selected channels drain independently. Backpressure on one channel never blocks a drain on another. It blocks input only while that channel is selected.
- Producer rule: in_data, in_sel and in_last stay stable while in_valid is high and in_ready is low.
- Reset values: out_valid = 0, out_data = 0, err_cnt = 0, state = IDLE, locked_sel = 0.
- Reset mid-operation: all held beats are discarded. A beat presented during the reset cycle is not accepted, and in_ready = 0 while reset = 1.

## Timing
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N, i.e. one cycle.
- Throughput: one beat per cycle sustained when the selected consumer holds out_ready = 1.
- Combinational paths: in_sel → in_ready and out_ready → in_ready. There is no path from in_* to out_*.
- err_cnt updates one cycle after the dropped accept.

## Configuration
- Macro DEMUX_LOCK_EN.
- Defined (packet lock mode): two-state FSM.
  - IDLE → LOCKED on an accepted beat with in_last = 0, capturing locked_sel <= in_sel.
  - LOCKED → IDLE on an accepted beat with in_last = 1.
  - In LOCKED, in_sel is ignored and every beat routes to locked_sel.
  - A single-beat packet (in_last = 1 in IDLE) stays in IDLE.
  - An out-of-range first beat locks too: the whole packet is dropped, and err_cnt counts each beat.
- Not defined: no FSM and no locked_sel register. Routing uses in_sel on every beat and in_last is ignored.

## Test plan
- Reset, then WIDTH=8, CH=4, all out_ready=1; send 0xA5 to sel 0,1,2,3 on consecutive cycles → each out_valid[i] pulses for 1 cycle, one cycle after its accept, with data 0xA5; in_ready is 1 throughout.
- out_ready[2]=0; send 0x11 then 0x22 to sel 2 → 0x11 held with out_valid[2]=1 and in_ready=0 on the second beat; raise out_ready[2] → 0x22 is loaded on the same edge 0x11 drains, and valid stays 1.
- CH=3, send 3 beats with sel=3 → in_ready=1, no out_valid asserts, err_cnt=3. Send 300 such beats → err_cnt=255.
- Channel 1 stalled and full; send to sel 0 → accepted normally while channel 1 keeps its data.
- With DEMUX_LOCK_EN: packet of beats 0x01, 0x02, 0x03 (last) with sel 2, 0, 3 → all three appear on channel 2, then the FSM returns to IDLE. Assert reset while in LOCKED → out_valid=0, err_cnt=0, next beat routes by in_sel.
